// File: rtl/cpu.sv
// -----------------------------------------------------------------------------
// cpu.sv
//
// FPGA top-level processor block. A compact MIPS core executes from an
// instruction memory and talks to a data memory plus LED/SSD registers. While
// uart_on is high the core is frozen, and a UART loader/dumper owns the
// memories. The loader assembles little-endian words from RX bytes. The dumper
// streams the first DM_LOAD_WORDS words of the selected memory out on TX.
//
// This file holds two modules:
//   pipeline_core : single-cycle MIPS subset core with a clock enable.
//   cpu           : memories, address decode, UART RX/TX, loader/dumper.
//
// cpu ports:
//   clk          system clock (100 MHz)
//   reset        async active-low; clears loader, dumper, core and LED/SSD
//                registers. Memory contents are kept.
//   uart_on      1 = UART owns the memories and the core is stalled
//   uart_mode    0 = receive/load, 1 = transmit/dump
//   uart_ram_id  0 = instruction memory, 1 = data memory
//   Rx_Serial    UART RX line, idle high
//   led[7:0]     [7] IM done, [6] DM done, [5:0] core LED register
//   ssd[11:0]    core seven-segment register
//   Tx_Serial    UART TX line, idle high
// -----------------------------------------------------------------------------

// pipeline_core ports:
//   clk, rst_n   clock and async active-low reset (PC returns to 0)
//   en           clock enable; while low, no state changes and no stores
//   pc           byte address of the current instruction
//   instr        instruction word at pc
//   dmem_*       data port; address and write data are combinational,
//                and load data is expected back in the same cycle.
// Supported: addu subu and or xor nor slt sll srl, addiu slti andi ori xori
// lui, lw sw, beq bne, j.
module pipeline_core (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   output logic [31:0] pc,
   input  logic [31:0] instr,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic        dmem_we,
   input  logic [31:0] dmem_rdata
);
   logic [31:0] pc_q, pc_d;
   logic [31:0] rf_q [32];

   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd, shamt;
   logic [15:0] imm;
   logic [31:0] rs_v, rt_v, simm, zimm, alu;
   logic [4:0]  wb_reg;
   logic        wb_en;

   assign op    = instr[31:26];
   assign rs    = instr[25:21];
   assign rt    = instr[20:16];
   assign rd    = instr[15:11];
   assign shamt = instr[10:6];
   assign funct = instr[5:0];
   assign imm   = instr[15:0];
   assign simm  = {{16{imm[15]}}, imm};
   assign zimm  = {16'd0, imm};

   // Register $0 reads as zero regardless of what was written into slot 0.
   assign rs_v = (rs == 5'd0) ? 32'd0 : rf_q[rs];
   assign rt_v = (rt == 5'd0) ? 32'd0 : rf_q[rt];

   assign pc         = pc_q;
   assign dmem_addr  = rs_v + simm;
   assign dmem_wdata = rt_v;

   // NOTE: every signal written in a combinational block gets a default at the
   // top, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      pc_d    = pc_q + 32'd4;
      alu     = 32'd0;
      wb_reg  = rt;
      wb_en   = 1'b0;
      dmem_we = 1'b0;
      case (op)
         6'h00: begin
            wb_reg = rd;
            wb_en  = 1'b1;
            case (funct)
               6'h00:   alu = rt_v << shamt;
               6'h02:   alu = rt_v >> shamt;
               6'h21:   alu = rs_v + rt_v;
               6'h23:   alu = rs_v - rt_v;
               6'h24:   alu = rs_v & rt_v;
               6'h25:   alu = rs_v | rt_v;
               6'h26:   alu = rs_v ^ rt_v;
               6'h27:   alu = ~(rs_v | rt_v);
               6'h2A:   alu = {31'd0, $signed(rs_v) < $signed(rt_v)};
               default: wb_en = 1'b0;
            endcase
         end
         6'h02: pc_d = {pc_q[31:28], instr[25:0], 2'b00};
         6'h04: if (rs_v == rt_v) pc_d = pc_q + 32'd4 + {simm[29:0], 2'b00};
         6'h05: if (rs_v != rt_v) pc_d = pc_q + 32'd4 + {simm[29:0], 2'b00};
         6'h09: begin alu = rs_v + simm; wb_en = 1'b1; end
         6'h0A: begin alu = {31'd0, $signed(rs_v) < $signed(simm)}; wb_en = 1'b1; end
         6'h0C: begin alu = rs_v & zimm; wb_en = 1'b1; end
         6'h0D: begin alu = rs_v | zimm; wb_en = 1'b1; end
         6'h0E: begin alu = rs_v ^ zimm; wb_en = 1'b1; end
         6'h0F: begin alu = {imm, 16'd0}; wb_en = 1'b1; end
         6'h23: begin alu = dmem_rdata; wb_en = 1'b1; end
         6'h2B: dmem_we = en;
         default: ;
      endcase
   end

   // NOTE: sequential state is always assigned with non-blocking (<=) so every
   // flop samples the values from before the clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  pc_q <= 32'd0;
      else if (en) pc_q <= pc_d;
   end

   // NOTE: storage arrays (register file, memories) have no reset; a reset
   // would force them into flops and nothing relies on their initial value.
   always_ff @(posedge clk) begin
      if (en && wb_en && (wb_reg != 5'd0)) rf_q[wb_reg] <= alu;
   end
endmodule

module cpu #(
   parameter int CLKS_PER_BIT  = 10417,
   parameter int IM_WORDS      = 256,
   parameter int DM_WORDS      = 256,
   parameter int IM_LOAD_WORDS = 10,
   parameter int DM_LOAD_WORDS = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        uart_on,
   input  logic        uart_mode,
   input  logic        uart_ram_id,
   input  logic        Rx_Serial,
   output logic [7:0]  led,
   output logic [11:0] ssd,
   output logic        Tx_Serial
);
   localparam int          IM_AW      = $clog2(IM_WORDS);
   localparam int          DM_AW      = $clog2(DM_WORDS);
   localparam logic [15:0] CPB        = 16'(CLKS_PER_BIT);
   localparam logic [15:0] CPB_HALF   = 16'(CLKS_PER_BIT / 2);
   localparam logic [15:0] IM_DEPTH   = 16'(IM_WORDS);
   localparam logic [15:0] DM_DEPTH   = 16'(DM_WORDS);
   localparam logic [15:0] IM_LOAD    = 16'(IM_LOAD_WORDS);
   localparam logic [15:0] DM_LOAD    = 16'(DM_LOAD_WORDS);
   localparam logic [15:0] DUMP_BYTES = 16'(4 * DM_LOAD_WORDS);

   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_CLEANUP} rx_state_e;
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

   logic [31:0] im_mem [IM_WORDS];
   logic [31:0] dm_mem [DM_WORDS];

   // ---------------- core and its address decode ----------------
   logic [31:0] core_pc, core_instr, core_addr, core_wdata, core_rdata;
   logic        core_we, core_dm_sel;
   logic        unused_pc;

   pipeline_core u_core (
      .clk        (clk),
      .rst_n      (reset),
      .en         (~uart_on),
      .pc         (core_pc),
      .instr      (core_instr),
      .dmem_addr  (core_addr),
      .dmem_wdata (core_wdata),
      .dmem_we    (core_we),
      .dmem_rdata (core_rdata)
   );

   assign unused_pc   = ^{core_pc[31:IM_AW+2], core_pc[1:0]};
   assign core_instr  = im_mem[core_pc[IM_AW+1:2]];
   assign core_dm_sel = (core_addr[31:30] == 2'b00);

   logic [5:0]  led_q, led_d;
   logic [11:0] ssd_q, ssd_d;

   always_comb begin
      core_rdata = 32'd0;
      if (core_dm_sel)                     core_rdata = dm_mem[core_addr[DM_AW+1:2]];
      else if (core_addr == 32'h4000_000C) core_rdata = {26'd0, led_q};
      else if (core_addr == 32'h4000_0010) core_rdata = {20'd0, ssd_q};
   end

   // core_we is already held low while the core is stalled.
   always_comb begin
      led_d = led_q;
      ssd_d = ssd_q;
      if (core_we && core_addr == 32'h4000_000C) led_d = core_wdata[5:0];
      if (core_we && core_addr == 32'h4000_0010) ssd_d = core_wdata[11:0];
   end

   // ---------------- UART receiver ----------------
   logic        rx_meta_q, rx_sync_q, rx_prev_q;
   rx_state_e   rx_state_q, rx_state_d;
   logic [15:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]  rx_bit_q, rx_bit_d;
   logic [7:0]  rx_shift_q, rx_shift_d;
   logic        rx_valid_q, rx_valid_d;
   logic        rx_enable;

   assign rx_enable = uart_on & ~uart_mode;

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_valid_d = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            rx_cnt_d = 16'd0;
            rx_bit_d = 3'd0;
            if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
         end
         RX_START: begin
            // Half a bit in: a line back high means a glitch, not a start bit.
            if (rx_cnt_q == CPB_HALF - 16'd1) begin
               rx_cnt_d   = 16'd0;
               rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            end else rx_cnt_d = rx_cnt_q + 16'd1;
         end
         RX_DATA: begin
            if (rx_cnt_q == CPB - 16'd1) begin
               rx_cnt_d   = 16'd0;
               rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
               rx_bit_d   = rx_bit_q + 3'd1;
               if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
            end else rx_cnt_d = rx_cnt_q + 16'd1;
         end
         RX_STOP: begin
            if (rx_cnt_q == CPB - 16'd1) begin
               rx_cnt_d   = 16'd0;
               rx_valid_d = rx_sync_q;  // a low stop bit discards the byte
               rx_state_d = RX_CLEANUP;
            end else rx_cnt_d = rx_cnt_q + 16'd1;
         end
         default: rx_state_d = RX_IDLE;
      endcase
      if (!rx_enable) begin
         rx_state_d = RX_IDLE;
         rx_valid_d = 1'b0;
      end
   end

   // ---------------- word assembly and loader counters ----------------
   logic [1:0]  im_bcnt_q, im_bcnt_d, dm_bcnt_q, dm_bcnt_d, cur_bcnt;
   logic [23:0] word_buf_q, word_buf_d;
   logic        id_prev_q;
   logic        wr_pend_q, wr_pend_d, wr_id_q, wr_id_d;
   logic [31:0] wr_word_q, wr_word_d;
   logic [15:0] im_wcnt_q, im_wcnt_d, dm_wcnt_q, dm_wcnt_d;
   logic        im_done_q, im_done_d, dm_done_q, dm_done_d;
   logic        im_we, uart_dm_we, dm_we;
   logic [DM_AW-1:0] dm_waddr;
   logic [31:0] dm_wdata;

   assign cur_bcnt = uart_ram_id ? dm_bcnt_q : im_bcnt_q;

   always_comb begin
      im_bcnt_d  = im_bcnt_q;
      dm_bcnt_d  = dm_bcnt_q;
      word_buf_d = word_buf_q;
      wr_pend_d  = 1'b0;
      wr_id_d    = wr_id_q;
      wr_word_d  = wr_word_q;
      im_wcnt_d  = im_wcnt_q;
      dm_wcnt_d  = dm_wcnt_q;
      // Switching memories drops the partial word of the one left behind;
      // the newly selected counter is already 0 from its own last switch-away.
      if (uart_ram_id != id_prev_q) begin
         if (id_prev_q) dm_bcnt_d = 2'd0;
         else           im_bcnt_d = 2'd0;
      end
      if (rx_valid_q) begin
         case (cur_bcnt)
            2'd0: word_buf_d[7:0]   = rx_shift_q;
            2'd1: word_buf_d[15:8]  = rx_shift_q;
            2'd2: word_buf_d[23:16] = rx_shift_q;
            default: begin
               wr_pend_d = 1'b1;
               wr_id_d   = uart_ram_id;
               wr_word_d = {rx_shift_q, word_buf_q};
            end
         endcase
         if (uart_ram_id) dm_bcnt_d = dm_bcnt_q + 2'd1;
         else             im_bcnt_d = im_bcnt_q + 2'd1;
      end
      // Counters saturate so an over-long load can never wrap onto word 0.
      if (wr_pend_q && !wr_id_q && im_wcnt_q != 16'hFFFF) im_wcnt_d = im_wcnt_q + 16'd1;
      if (wr_pend_q &&  wr_id_q && dm_wcnt_q != 16'hFFFF) dm_wcnt_d = dm_wcnt_q + 16'd1;
      im_done_d = im_done_q | (im_wcnt_q >= IM_LOAD);
      dm_done_d = dm_done_q | (dm_wcnt_q >= DM_LOAD);
   end

   assign im_we      = wr_pend_q & ~wr_id_q & (im_wcnt_q < IM_DEPTH);
   assign uart_dm_we = wr_pend_q &  wr_id_q & (dm_wcnt_q < DM_DEPTH);
   assign dm_we      = uart_on ? uart_dm_we : (core_we & core_dm_sel);
   assign dm_waddr   = uart_on ? dm_wcnt_q[DM_AW-1:0] : core_addr[DM_AW+1:2];
   assign dm_wdata   = uart_on ? wr_word_q : core_wdata;

   always_ff @(posedge clk) begin
      if (im_we) im_mem[im_wcnt_q[IM_AW-1:0]] <= wr_word_q;
   end

   always_ff @(posedge clk) begin
      if (dm_we) dm_mem[dm_waddr] <= dm_wdata;
   end

   // ---------------- dumper and UART transmitter ----------------
   logic        dump_go, go_prev_q;
   logic        dump_active_q, dump_active_d, dump_id_q, dump_id_d;
   logic [15:0] dump_idx_q, dump_idx_d;
   logic [31:0] dump_word;
   logic [7:0]  dump_byte;
   logic        load_next;
   tx_state_e   tx_state_q, tx_state_d;
   logic [15:0] tx_cnt_q, tx_cnt_d;
   logic [2:0]  tx_bit_q, tx_bit_d;
   logic [7:0]  tx_byte_q, tx_byte_d;
   logic        tx_q, tx_d;

   assign dump_go   = uart_on & uart_mode;
   assign dump_word = dump_id_q ? dm_mem[dump_idx_q[DM_AW+1:2]] : im_mem[dump_idx_q[IM_AW+1:2]];
   assign load_next = dump_active_q & dump_go & (dump_idx_q < DUMP_BYTES);

   always_comb begin
      case (dump_idx_q[1:0])
         2'd0:    dump_byte = dump_word[7:0];
         2'd1:    dump_byte = dump_word[15:8];
         2'd2:    dump_byte = dump_word[23:16];
         default: dump_byte = dump_word[31:24];
      endcase
   end

   always_comb begin
      tx_state_d    = tx_state_q;
      tx_cnt_d      = tx_cnt_q;
      tx_bit_d      = tx_bit_q;
      tx_byte_d     = tx_byte_q;
      dump_idx_d    = dump_idx_q;
      dump_active_d = dump_active_q;
      dump_id_d     = dump_id_q;
      case (tx_state_q)
         TX_IDLE: begin
            if (load_next) begin
               tx_byte_d  = dump_byte;
               dump_idx_d = dump_idx_q + 16'd1;
               tx_cnt_d   = 16'd0;
               tx_state_d = TX_START;
            end else if (dump_active_q) begin
               dump_active_d = 1'b0;  // finished, or aborted between bytes
            end
         end
         TX_START: begin
            if (tx_cnt_q == CPB - 16'd1) begin
               tx_cnt_d   = 16'd0;
               tx_bit_d   = 3'd0;
               tx_state_d = TX_DATA;
            end else tx_cnt_d = tx_cnt_q + 16'd1;
         end
         TX_DATA: begin
            if (tx_cnt_q == CPB - 16'd1) begin
               tx_cnt_d = 16'd0;
               if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
               else                  tx_bit_d   = tx_bit_q + 3'd1;
            end else tx_cnt_d = tx_cnt_q + 16'd1;
         end
         default: begin
            // Chain straight into the next start bit so bytes leave gap-free.
            if (tx_cnt_q == CPB - 16'd1) begin
               tx_cnt_d = 16'd0;
               if (load_next) begin
                  tx_byte_d  = dump_byte;
                  dump_idx_d = dump_idx_q + 16'd1;
                  tx_state_d = TX_START;
               end else tx_state_d = TX_IDLE;
            end else tx_cnt_d = tx_cnt_q + 16'd1;
         end
      endcase
      if (dump_go && !go_prev_q) begin
         dump_active_d = 1'b1;
         dump_id_d     = uart_ram_id;
         dump_idx_d    = 16'd0;
      end
      // The line level follows the state being entered, so Tx_Serial is a flop.
      case (tx_state_d)
         TX_START: tx_d = 1'b0;
         TX_DATA:  tx_d = tx_byte_d[tx_bit_d];
         default:  tx_d = 1'b1;
      endcase
   end

   // ---------------- state registers ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         led_q         <= 6'd0;
         ssd_q         <= 12'd0;
         rx_meta_q     <= 1'b1;
         rx_sync_q     <= 1'b1;
         rx_prev_q     <= 1'b1;
         rx_state_q    <= RX_IDLE;
         rx_cnt_q      <= 16'd0;
         rx_bit_q      <= 3'd0;
         rx_shift_q    <= 8'd0;
         rx_valid_q    <= 1'b0;
         im_bcnt_q     <= 2'd0;
         dm_bcnt_q     <= 2'd0;
         word_buf_q    <= 24'd0;
         id_prev_q     <= 1'b0;
         wr_pend_q     <= 1'b0;
         wr_id_q       <= 1'b0;
         wr_word_q     <= 32'd0;
         im_wcnt_q     <= 16'd0;
         dm_wcnt_q     <= 16'd0;
         im_done_q     <= 1'b0;
         dm_done_q     <= 1'b0;
         go_prev_q     <= 1'b0;
         dump_active_q <= 1'b0;
         dump_id_q     <= 1'b0;
         dump_idx_q    <= 16'd0;
         tx_state_q    <= TX_IDLE;
         tx_cnt_q      <= 16'd0;
         tx_bit_q      <= 3'd0;
         tx_byte_q     <= 8'd0;
         tx_q          <= 1'b1;
      end else begin
         led_q         <= led_d;
         ssd_q         <= ssd_d;
         rx_meta_q     <= Rx_Serial;
         rx_sync_q     <= rx_meta_q;
         rx_prev_q     <= rx_sync_q;
         rx_state_q    <= rx_state_d;
         rx_cnt_q      <= rx_cnt_d;
         rx_bit_q      <= rx_bit_d;
         rx_shift_q    <= rx_shift_d;
         rx_valid_q    <= rx_valid_d;
         im_bcnt_q     <= im_bcnt_d;
         dm_bcnt_q     <= dm_bcnt_d;
         word_buf_q    <= word_buf_d;
         id_prev_q     <= uart_ram_id;
         wr_pend_q     <= wr_pend_d;
         wr_id_q       <= wr_id_d;
         wr_word_q     <= wr_word_d;
         im_wcnt_q     <= im_wcnt_d;
         dm_wcnt_q     <= dm_wcnt_d;
         im_done_q     <= im_done_d;
         dm_done_q     <= dm_done_d;
         go_prev_q     <= dump_go;
         dump_active_q <= dump_active_d;
         dump_id_q     <= dump_id_d;
         dump_idx_q    <= dump_idx_d;
         tx_state_q    <= tx_state_d;
         tx_cnt_q      <= tx_cnt_d;
         tx_bit_q      <= tx_bit_d;
         tx_byte_q     <= tx_byte_d;
         tx_q          <= tx_d;
      end
   end

   assign led       = {im_done_q, dm_done_q, led_q};
   assign ssd       = ssd_q;
   assign Tx_Serial = tx_q;
endmodule

// File: tb/tb_cpu.sv
// -----------------------------------------------------------------------------
// tb_cpu.sv
//
// Self-checking bench for cpu. The bench loads words over a serial line it
// drives itself, dumps data memory and decodes the TX frames, then runs a
// short program and checks its LED/SSD/memory effects. Expected values come
// from word arrays the bench builds (random words, a fixed program) and from
// plain arithmetic on them. The UART bit time is shortened to keep runs short.
// -----------------------------------------------------------------------------
module tb_cpu;
   localparam int CPB = 16;

   logic        clk = 1'b0;
   logic        reset, uart_on, uart_mode, uart_ram_id, rx_serial;
   logic [7:0]  led;
   logic [11:0] ssd;
   logic        tx_serial;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   logic [31:0] im_words [10];
   logic [31:0] prog     [10];
   logic [31:0] dm_words [3];
   logic [11:0] ssd_val;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   cpu #(.CLKS_PER_BIT(CPB)) dut (
      .clk         (clk),
      .reset       (reset),
      .uart_on     (uart_on),
      .uart_mode   (uart_mode),
      .uart_ram_id (uart_ram_id),
      .Rx_Serial   (rx_serial),
      .led         (led),
      .ssd         (ssd),
      .Tx_Serial   (tx_serial)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance n clocks and settle just past the edge, away from sampling.
   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      rx_serial = 1'b0;
      wait_clks(CPB);
      for (int i = 0; i < 8; i++) begin
         rx_serial = b[i];
         wait_clks(CPB);
      end
      rx_serial = stop_bit;
      wait_clks(CPB);
      rx_serial = 1'b1;
      wait_clks(4);
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send_byte(8'((w >> (8 * i)) & 32'hFF), 1'b1);
   endtask

   // Decode one frame from Tx_Serial, sampling mid-bit.
   task automatic recv_byte(input string tag, output logic [7:0] b, output int start_cyc);
      int n = 0;
      b = 8'h00;
      start_cyc = cyc;
      while (tx_serial !== 1'b0 && n < 40 * CPB) begin
         wait_clks(1);
         n++;
      end
      if (tx_serial !== 1'b0) begin
         check({tag, "_timeout"}, 32'd0, 32'd1);
         return;
      end
      start_cyc = cyc;
      wait_clks(CPB / 2);
      check({tag, "_start"}, 32'(tx_serial), 32'd0);
      for (int i = 0; i < 8; i++) begin
         wait_clks(CPB);
         b[i] = tx_serial;
      end
      wait_clks(CPB);
      check({tag, "_stop"}, 32'(tx_serial), 32'd1);
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] rb;
      int         sc, prev_sc;
      logic       saw_low;

      reset = 1'b0; uart_on = 1'b1; uart_mode = 1'b0; uart_ram_id = 1'b0; rx_serial = 1'b1;
      wait_clks(5);
      reset = 1'b1;
      wait_clks(3);
      check("reset_led", 32'(led), 32'h00);
      check("reset_ssd", 32'(ssd), 32'h000);
      check("reset_tx", 32'(tx_serial), 32'd1);

      // ---- load 10 instruction words, one corrupted byte in between ----
      im_words[0] = 32'h3C08_1234;
      for (int i = 1; i < 10; i++) im_words[i] = $urandom;
      send_word(im_words[0]);
      wait_clks(3);
      check("im0_first_word", dut.im_mem[0], 32'h3C08_1234);
      check("im_done_after_1", 32'(led[7]), 32'd0);
      for (int i = 1; i < 10; i++) begin
         if (i == 9) check("im_done_after_9", 32'(led[7]), 32'd0);
         send_word(im_words[i]);
         if (i == 4) send_byte(8'($urandom_range(0, 255)), 1'b0);
      end
      wait_clks(3);
      check("im_done_after_10", 32'(led[7]), 32'd1);
      check("dm_done_still_0", 32'(led[6]), 32'd0);
      for (int i = 0; i < 10; i++) check($sformatf("im_word_%0d", i), dut.im_mem[i], im_words[i]);

      // ---- partial word then reset mid-frame: all of it must be lost ----
      send_byte(8'($urandom_range(0, 255)), 1'b1);
      send_byte(8'($urandom_range(0, 255)), 1'b1);
      rx_serial = 1'b0;
      wait_clks(3 * CPB);
      reset = 1'b0;
      rx_serial = 1'b1;
      wait_clks(2);
      check("midframe_reset_led", 32'(led), 32'h00);
      check("midframe_reset_tx", 32'(tx_serial), 32'd1);
      reset = 1'b1;
      wait_clks(2 * CPB);

      // ---- program: LED <= 0x2A, SSD <= random, DM[3] <= DM[2] + DM[0] ----
      ssd_val = 12'($urandom);
      prog[0] = 32'h3C08_4000;             // lui  $8, 0x4000
      prog[1] = 32'h3409_002A;             // ori  $9, $0, 0x2A
      prog[2] = 32'hAD09_000C;             // sw   $9, 12($8)
      prog[3] = 32'h340A_0000 | {20'd0, ssd_val}; // ori $10, $0, ssd_val
      prog[4] = 32'hAD0A_0010;             // sw   $10, 16($8)
      prog[5] = 32'h8C0B_0008;             // lw   $11, 8($0)
      prog[6] = 32'h8C0D_0000;             // lw   $13, 0($0)
      prog[7] = 32'h016D_6021;             // addu $12, $11, $13
      prog[8] = 32'hAC0C_000C;             // sw   $12, 12($0)
      prog[9] = 32'h1000_FFFF;             // beq  $0, $0, -1
      for (int i = 0; i < 10; i++) send_word(prog[i]);
      wait_clks(3);
      check("prog_word_0", dut.im_mem[0], prog[0]);
      check("prog_word_9", dut.im_mem[9], prog[9]);

      // ---- data words; a partial word abandoned by switching memories ----
      dm_words[0] = 32'h0000_0001;
      dm_words[1] = 32'h0000_0002;
      dm_words[2] = 32'hDEAD_BEEF;
      uart_ram_id = 1'b1;
      wait_clks(2);
      send_byte(8'($urandom_range(0, 255)), 1'b1);
      send_byte(8'($urandom_range(0, 255)), 1'b1);
      uart_ram_id = 1'b0;
      wait_clks(2);
      uart_ram_id = 1'b1;
      wait_clks(2);
      check("dm_done_before_load", 32'(led[6]), 32'd0);
      for (int i = 0; i < 3; i++) send_word(dm_words[i]);
      wait_clks(3);
      check("dm_done_after_3", 32'(led[6]), 32'd1);

      // ---- dump DM words 0..2 over TX ----
      uart_mode = 1'b1;
      prev_sc = 0;
      for (int k = 0; k < 12; k++) begin
         recv_byte($sformatf("dump%0d", k), rb, sc);
         check($sformatf("dump_byte_%0d", k), 32'(rb), (dm_words[k / 4] >> (8 * (k % 4))) & 32'hFF);
         if (k > 0) check($sformatf("dump_spacing_%0d", k), 32'(sc - prev_sc), 32'(10 * CPB));
         prev_sc = sc;
      end
      saw_low = 1'b0;
      for (int i = 0; i < 30 * CPB; i++) begin
         wait_clks(1);
         if (tx_serial !== 1'b1) saw_low = 1'b1;
      end
      check("dump_runs_once", 32'(saw_low), 32'd0);

      // ---- run the program from PC 0 ----
      uart_mode = 1'b0;
      uart_on = 1'b0;
      reset = 1'b0;
      wait_clks(2);
      reset = 1'b1;
      wait_clks(60);
      check("run_led", 32'(led), 32'h2A);
      check("run_ssd", 32'(ssd), 32'(ssd_val));
      check("run_dm3_sum", dut.dm_mem[3], dm_words[2] + dm_words[0]);
      check("run_dm2_kept", dut.dm_mem[2], dm_words[2]);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
